// File: rtl/ram_bist_seq.sv
// Write/read-back BIST sequencer for asynchronous ram128x16-family SRAMs.
// Define RAM_BIST_INVERT_EN to add a second pass using the inverted pattern.
module ram_bist_seq #(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 7,
  parameter logic [15:0] SEED_DEF = 16'd9804
) (
  input  logic              clk,
  input  logic              _rst,
  input  logic              start,
  input  logic              seed_ld,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+1:0] err_count,
  output logic [ADDR_W-1:0] first_err_adrs,
  output logic [DATA_W-1:0] first_err_data,
  output logic [ADDR_W-1:0] adrs,
  output logic [DATA_W-1:0] wdata,
  output logic              wdata_en,
  output logic              _ce,
  output logic              _we,
  output logic              _oe,
  input  logic [DATA_W-1:0] rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_SETUP, S_W_PULSE, S_W_HOLD, S_R_SETUP, S_R_SAMPLE, S_DONE
  } state_t;

  localparam logic [ADDR_W:0]   ADDR_LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W+1:0] ERR_MAX   = '1;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     addr_q, addr_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [ADDR_W+1:0]   err_q, err_d;
  logic [ADDR_W-1:0]   fadr_q, fadr_d;
  logic [DATA_W-1:0]   fdata_q, fdata_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [DATA_W-1:0]   pat, exp_w;
  logic                last;

  assign pat  = seed_q + DATA_W'(addr_q[ADDR_W-1:0]);
  assign last = (addr_q == ADDR_LAST);

`ifdef RAM_BIST_INVERT_EN
  logic inv_q, inv_d;
  assign exp_w = inv_q ? ~pat : pat;
`else
  assign exp_w = pat;
`endif

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      fadr_q  <= '0;
      fdata_q <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef RAM_BIST_INVERT_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      fadr_q  <= fadr_d;
      fdata_q <= fdata_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef RAM_BIST_INVERT_EN
      inv_q   <= inv_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    seed_d  = seed_q;
    err_d   = err_q;
    fadr_d  = fadr_q;
    fdata_d = fdata_q;
    done_d  = done_q;
    pass_d  = pass_q;
`ifdef RAM_BIST_INVERT_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          seed_d  = seed_ld ? seed : DATA_W'(SEED_DEF);
          addr_d  = '0;
          err_d   = '0;
          fadr_d  = '0;
          fdata_d = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
`ifdef RAM_BIST_INVERT_EN
          inv_d   = 1'b0;
`endif
          state_d = S_W_SETUP;
        end
      end
      S_W_SETUP: state_d = S_W_PULSE;
      S_W_PULSE: state_d = S_W_HOLD;
      S_W_HOLD: begin
        if (last) begin
          addr_d  = '0;
          state_d = S_R_SETUP;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_W_SETUP;
        end
      end
      S_R_SETUP: state_d = S_R_SAMPLE;
      S_R_SAMPLE: begin
        if (rdata != exp_w) begin
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          // err_q never returns to zero once bumped, so this marks the first miss
          if (err_q == '0) begin
            fadr_d  = addr_q[ADDR_W-1:0];
            fdata_d = rdata;
          end
        end
        if (last) begin
          addr_d  = '0;
`ifdef RAM_BIST_INVERT_EN
          if (!inv_q) begin
            inv_d   = 1'b1;
            state_d = S_W_SETUP;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
`else
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
`endif
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_R_SETUP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset forces them high at once
  always_comb begin
    _ce      = 1'b1;
    _we      = 1'b1;
    _oe      = 1'b1;
    wdata_en = 1'b0;
    case (state_q)
      S_W_SETUP, S_W_HOLD: begin _ce = 1'b0; wdata_en = 1'b1; end
      S_W_PULSE:           begin _ce = 1'b0; _we = 1'b0; wdata_en = 1'b1; end
      S_R_SETUP, S_R_SAMPLE: begin _ce = 1'b0; _oe = 1'b0; end
      default: ;
    endcase
  end

  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_adrs = fadr_q;
  assign first_err_data = fdata_q;
  assign adrs           = addr_q[ADDR_W-1:0];
  assign wdata          = exp_w;

endmodule

// File: tb/tb_ram_bist_seq.sv
// Scoreboard bench for ram_bist_seq against a behavioural 128x16 async SRAM model.
module tb_ram_bist_seq;
`ifdef RAM_BIST_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif
  localparam int LAT = INV ? 1281 : 641;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, seed_ld = 1'b0;
  logic [15:0] seed = '0, wdata, rdata, first_err_data;
  logic        busy, done, pass, wdata_en, ce_n, we_n, oe_n;
  logic [8:0]  err_count;
  logic [6:0]  first_err_adrs, adrs;

  ram_bist_seq dut (
    .clk(clk), ._rst(rst_n), .start(start), .seed_ld(seed_ld), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_adrs(first_err_adrs), .first_err_data(first_err_data),
    .adrs(adrs), .wdata(wdata), .wdata_en(wdata_en),
    ._ce(ce_n), ._we(we_n), ._oe(oe_n), .rdata(rdata)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [128];
  logic        fault_en = 1'b0;
  always @(posedge clk) if (!ce_n && !we_n) mem[adrs] <= wdata;
  assign rdata = (!ce_n && !oe_n) ?
                 (mem[adrs] & ((fault_en && adrs == 7'd5) ? 16'hFFFE : 16'hFFFF)) : 16'h0;

  typedef struct {
    int          lat;
    logic        pass;
    logic [8:0]  err;
    logic [6:0]  fa;
    logic [15:0] fd;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0, fails = 0, viol = 0, cyc = 0, start_cyc = 0;
  logic done_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (!we_n && !oe_n) viol++;
      if (wdata_en && !oe_n) viol++;
    end
    if (done && !done_prev) begin
      if (sbq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got done with empty scoreboard");
      end else begin
        e = sbq.pop_front();
        chk("done_latency", cyc - start_cyc, e.lat);
        chk("pass", {31'd0, pass}, {31'd0, e.pass});
        chk("err_count", {23'd0, err_count}, {23'd0, e.err});
        chk("first_err_adrs", {25'd0, first_err_adrs}, {25'd0, e.fa});
        chk("first_err_data", {16'd0, first_err_data}, {16'd0, e.fd});
      end
    end
    done_prev = done;
  end

  task automatic run_test(input logic ld, input logic [15:0] sd, input int pulse_at, input exp_t e);
    int n;
    @(negedge clk);
    seed_ld = ld; seed = sd; start = 1'b1; start_cyc = cyc;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    n = 1;
    while (!done && n < 3000) begin
      if (n == pulse_at) begin start = 1'b1; seed_ld = 1'b1; seed = 16'h1234; end
      else start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done after %0d cycles, required %0d", n, LAT);
      sbq.delete();
    end else chk("busy_in_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  function automatic logic [15:0] fin(input logic [15:0] s, input int a);
    logic [15:0] p;
    p = s + 16'(a);
    return INV ? ~p : p;
  endfunction

  initial begin
    exp_t ok, bad;
    ok  = '{LAT, 1'b1, 9'd0, 7'd0, 16'd0};
    bad = '{LAT, 1'b0, 9'd1, 7'd5, 16'h2650};
    for (int i = 0; i < 128; i++) mem[i] = 16'h0;

    repeat (3) @(negedge clk);
    chk("rst_ce", {31'd0, ce_n}, 32'd1);
    chk("rst_we", {31'd0, we_n}, 32'd1);
    chk("rst_oe", {31'd0, oe_n}, 32'd1);
    chk("rst_wdata_en", {31'd0, wdata_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_err", {23'd0, err_count}, 32'd0);
    chk("rst_fadr", {25'd0, first_err_adrs}, 32'd0);
    chk("rst_fdata", {16'd0, first_err_data}, 32'd0);
    chk("rst_adrs", {25'd0, adrs}, 32'd0);
    chk("rst_wdata", {16'd0, wdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_test(1'b0, 16'h0, 0, ok);
    chk("mem0_default", {16'd0, mem[0]}, {16'd0, INV ? 16'hD9B3 : 16'h264C});
    chk("mem127_default", {16'd0, mem[127]}, {16'd0, fin(16'd9804, 127)});
    chk("mem5_default", {16'd0, mem[5]}, {16'd0, fin(16'd9804, 5)});

    fault_en = 1'b1;
    run_test(1'b0, 16'h0, 0, bad);
    fault_en = 1'b0;

    run_test(1'b1, 16'hFFF0, 0, ok);
    chk("mem10_wrap", {16'd0, mem[16]}, {16'd0, INV ? 16'hFFFF : 16'h0000});
    chk("mem7f_wrap", {16'd0, mem[127]}, {16'd0, INV ? 16'hFF90 : 16'h006F});

    run_test(1'b0, 16'h0, 200, ok);
    chk("mem1_after_ignored_start", {16'd0, mem[1]}, {16'd0, fin(16'd9804, 1)});

    @(negedge clk);
    seed_ld = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ce", {31'd0, ce_n}, 32'd1);
    chk("midrst_we", {31'd0, we_n}, 32'd1);
    chk("midrst_oe", {31'd0, oe_n}, 32'd1);
    chk("midrst_wdata_en", {31'd0, wdata_en}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_adrs", {25'd0, adrs}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_test(1'b0, 16'h0, 0, ok);

    chk("protocol_violations", viol, 32'd0);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
